iter_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the iterative multiplier/divider datapaths.

---
 rtl/iter_seq_ctrl_if.sv | 30 +++
 rtl/iter_seq_ctrl.sv | 101 ++++++++++
 tb/tb_iter_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_seq_ctrl_if.sv
// Run/Ready handshake and datapath strobes of the iterative sequencer.
// master = requester/datapath side, slave = sequencer side.
interface iter_seq_ctrl_if #(
  parameter int STEPS = 32
);
  localparam int CNT_W = $clog2(STEPS);

  logic             Run;
  logic             Abort;
  logic             Ack;
  logic             early_done;
  logic             load;
  logic             step_en;
  logic [CNT_W-1:0] step_idx;
  logic             pre_finish;
  logic             Ready;
  logic             Busy;

  modport master (
    output Run, Abort, Ack, early_done,
    input  load, step_en, step_idx,
    input  pre_finish, Ready, Busy
  );

  modport slave (
    input  Run, Abort, Ack, early_done,
    output load, step_en, step_idx,
    output pre_finish, Ready, Busy
  );
endinterface

// File: rtl/iter_seq_ctrl.sv
// Moore sequencer for iterative mul/div datapaths: LOAD, STEPS x ITER, FINAL, DONE.
// Optional EARLY_TERM_EN: early_done in ITER jumps straight to FINAL.
module iter_seq_ctrl #(
  parameter int STEPS = 32
) (
  input  logic           clk,
  input  logic           Reset,
  iter_seq_ctrl_if.slave s
);
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (STEPS < 2 || STEPS > 255) begin : g_bad_steps
    $error("iter_seq_ctrl: STEPS out of range 2..255");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FINAL,
    DONE
  } state_t;

  state_t state;
  logic   early;

`ifdef EARLY_TERM_EN
  assign early = s.early_done;
`else
  logic unused_early;
  assign unused_early = s.early_done;
  assign early        = 1'b0;
`endif

  // Outputs are registered alongside the state they decode, so every
  // branch sets the strobes that belong to its destination state.
  always_ff @(posedge clk) begin
    s.load       <= 1'b0;
    s.step_en    <= 1'b0;
    s.step_idx   <= '0;
    s.pre_finish <= 1'b0;
    s.Ready      <= 1'b0;
    s.Busy       <= 1'b0;
    if (Reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (s.Run) begin
            state  <= LOAD;
            s.load <= 1'b1;
            s.Busy <= 1'b1;
          end
        end
        LOAD: begin
          if (s.Abort) begin
            state <= IDLE;
          end else begin
            state     <= ITER;
            s.step_en <= 1'b1;
            s.Busy    <= 1'b1;
          end
        end
        ITER: begin
          if (s.Abort) begin
            state <= IDLE;
          end else if (early || s.step_idx == LAST) begin
            state        <= FINAL;
            s.pre_finish <= 1'b1;
            s.Busy       <= 1'b1;
          end else begin
            s.step_en  <= 1'b1;
            s.step_idx <= s.step_idx + 1'b1;
            s.Busy     <= 1'b1;
          end
        end
        FINAL: begin
          if (s.Abort) begin
            state <= IDLE;
          end else begin
            state   <= DONE;
            s.Ready <= 1'b1;
          end
        end
        DONE: begin
          if (s.Run) begin
            state  <= LOAD;
            s.load <= 1'b1;
            s.Busy <= 1'b1;
          end else if (s.Ack) begin
            state <= IDLE;
          end else begin
            s.Ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Bench for iter_seq_ctrl: STEPS=32 and STEPS=2 instances against an
// offset-based reference model, plus hand-computed latency expectations.
module tb_iter_seq_ctrl;
  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  iter_seq_ctrl_if #(.STEPS(32)) ia();
  iter_seq_ctrl_if #(.STEPS(2))  ib();

  iter_seq_ctrl #(.STEPS(32)) u_a (
    .clk(clk), .Reset(Reset), .s(ia.slave)
  );
  iter_seq_ctrl #(.STEPS(2)) u_b (
    .clk(clk), .Reset(Reset), .s(ib.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // k = cycles since the accepted Run (1 = load, 2..n+1 = steps,
  // n+2 = pre_finish), 0 when no operation is in flight.
  typedef struct {
    int k;
    bit rdy;
    int n;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, int steps, bit rst,
                                 bit run, bit abrt, bit ack, bit ed);
    mdl_t r = m;
    if (rst) begin
      r.k = 0; r.rdy = 1'b0;
    end else if (m.rdy) begin
      if (run) begin
        r.rdy = 1'b0; r.k = 1; r.n = steps;
      end else if (ack) begin
        r.rdy = 1'b0;
      end
    end else if (m.k == 0) begin
      if (run) begin
        r.k = 1; r.n = steps;
      end
    end else if (abrt) begin
      r.k = 0;
    end else if (m.k == m.n + 2) begin
      r.k = 0; r.rdy = 1'b1;
    end else begin
      if (EARLY && ed && m.k >= 2 && m.k <= m.n + 1) r.n = m.k - 1;
      r.k = m.k + 1;
    end
    return r;
  endfunction

  // {load, step_en, idx[7:0], pre_finish, Ready, Busy}
  function automatic logic [12:0] exp_vec(mdl_t m);
    bit st = (m.k >= 2 && m.k <= m.n + 1);
    logic [7:0] idx = st ? 8'(m.k - 2) : 8'd0;
    return {m.k == 1, st, idx, m.k == m.n + 2, m.rdy, m.k >= 1};
  endfunction

  mdl_t ma = '{k: 0, rdy: 1'b0, n: 32};
  mdl_t mb = '{k: 0, rdy: 1'b0, n: 2};

  always @(posedge clk) begin
    ma <= mstep(ma, 32, Reset, ia.Run, ia.Abort, ia.Ack, ia.early_done);
    mb <= mstep(mb, 2, Reset, ib.Run, ib.Abort, ib.Ack, ib.early_done);
  end

  logic [12:0] va, vb;
  assign va = {ia.load, ia.step_en, 8'(ia.step_idx),
               ia.pre_finish, ia.Ready, ia.Busy};
  assign vb = {ib.load, ib.step_en, 8'(ib.step_idx),
               ib.pre_finish, ib.Ready, ib.Busy};

  always @(negedge clk) begin
    chk("a_outputs", 32'(va), 32'(exp_vec(ma)));
    chk("b_outputs", 32'(vb), 32'(exp_vec(mb)));
    chk("a_onehot", 32'($onehot0({ia.load, ia.step_en,
                                  ia.pre_finish, ia.Ready})), 1);
    chk("b_onehot", 32'($onehot0({ib.load, ib.step_en,
                                  ib.pre_finish, ib.Ready})), 1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_a();
    ia.Run = 1'b1;
    tick();
    ia.Run = 1'b0;
  endtask

  // Called at the negedge of cycle 1 (load); returns step_en count and
  // the cycle in which Ready first appears. ed = idx to raise early_done.
  task automatic measure(input int ed, output int steps, output int rdy);
    steps = 0;
    rdy   = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) tick();
      ia.early_done = ia.step_en && (32'(ia.step_idx) == ed);
      if (ia.step_en) begin
        chk("idx_seq", 32'(ia.step_idx), 32'(steps));
        steps++;
      end
      if (ia.Ready) begin
        rdy = c;
        break;
      end
    end
    ia.early_done = 1'b0;
  endtask

  task automatic wait_idx(int v);
    for (int i = 0; i < 100; i++) begin
      if (ia.step_en && 32'(ia.step_idx) == v) return;
      tick();
    end
    chk("wait_idx_timeout", 0, 1);
  endtask

  task automatic ack_a();
    ia.Ack = 1'b1;
    tick();
    ia.Ack = 1'b0;
  endtask

  int ns, rc;

  initial begin
    Reset = 1'b1;
    {ia.Run, ia.Abort, ia.Ack, ia.early_done} = '0;
    {ib.Run, ib.Abort, ib.Ack, ib.early_done} = '0;
    tick();
    tick();
    chk("reset_a", 32'(va), 0);
    chk("reset_b", 32'(vb), 0);
    Reset = 1'b0;
    tick();

    // Full 32-step op, Ready held until Ack at cycle 40
    start_a();
    chk("t1_load", 32'(ia.load), 1);
    measure(-1, ns, rc);
    chk("t1_steps", ns, 32);
    chk("t1_ready_cyc", rc, 35);
    for (int c = 36; c <= 40; c++) begin
      tick();
      ia.Abort = (c == 36);
      chk("t1_ready_held", 32'(ia.Ready), 1);
    end
    ia.Abort = 1'b0;
    ia.Ack = 1'b1;
    tick();
    ia.Ack = 1'b0;
    chk("t1_ready_drop", 32'(ia.Ready), 0);

    // Abort at idx 10, Ack during busy is ignored
    tick();
    start_a();
    tick();
    ia.Ack = 1'b1;
    tick();
    ia.Ack = 1'b0;
    wait_idx(10);
    ia.Abort = 1'b1;
    tick();
    ia.Abort = 1'b0;
    chk("t2_busy", 32'(ia.Busy), 0);
    chk("t2_ready", 32'(ia.Ready), 0);
    tick();
    chk("t2_no_ready", 32'(ia.Ready), 0);
    start_a();
    measure(-1, ns, rc);
    chk("t2_steps", ns, 32);
    chk("t2_ready_cyc", rc, 35);
    ack_a();

    // Reset at idx 20 while Run is held high
    ia.Run = 1'b1;
    tick();
    wait_idx(20);
    Reset = 1'b1;
    tick();
    chk("t3_zero", 32'(va), 0);
    Reset = 1'b0;
    tick();
    chk("t3_reload", 32'(ia.load), 1);
    ia.Run = 1'b0;
    measure(-1, ns, rc);
    chk("t3_steps", ns, 32);
    chk("t3_ready_cyc", rc, 35);

    // Run and Ack together in DONE: restart wins
    ia.Run = 1'b1;
    ia.Ack = 1'b1;
    tick();
    ia.Run = 1'b0;
    ia.Ack = 1'b0;
    chk("t4_ready", 32'(ia.Ready), 0);
    chk("t4_load", 32'(ia.load), 1);
    measure(-1, ns, rc);
    chk("t4_ready_cyc", rc, 35);
    ack_a();

    // STEPS=2 instance, Run pulse during busy ignored
    ib.Run = 1'b1;
    tick();
    ib.Run = 1'b0;
    chk("t5_load", 32'(ib.load), 1);
    tick();
    chk("t5_step0", 32'({ib.step_en, ib.step_idx}), 32'b10);
    ib.Run = 1'b1;
    tick();
    ib.Run = 1'b0;
    chk("t5_step1", 32'({ib.step_en, ib.step_idx}), 32'b11);
    tick();
    chk("t5_pre", 32'(ib.pre_finish), 1);
    tick();
    chk("t5_ready", 32'(ib.Ready), 1);
    ib.Ack = 1'b1;
    tick();
    ib.Ack = 1'b0;

    // STEPS=2: Abort on the last step wins over finishing
    ib.Run = 1'b1;
    tick();
    ib.Run = 1'b0;
    tick();
    tick();
    chk("t5_last", 32'({ib.step_en, ib.step_idx}), 32'b11);
    ib.Abort = 1'b1;
    tick();
    ib.Abort = 1'b0;
    chk("t5_abort_busy", 32'(ib.Busy), 0);
    tick();
    chk("t5_abort_rdy", 32'(ib.Ready), 0);

    // early_done at idx 5
    start_a();
    measure(5, ns, rc);
    chk("t6_steps", ns, EARLY ? 6 : 32);
    chk("t6_ready_cyc", rc, EARLY ? 9 : 35);
    ack_a();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
